// File: rtl/hif_q_pkg.sv
// hif_q_pkg: queue geometry, reader FSM states and modulo-DEPTH address increment
package hif_q_pkg;
    localparam int DEPTH  = 1536;
    localparam int ADDR_W = 11;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {IDLE, SEQ, DRAIN} rd_state_t;

    function automatic logic [ADDR_W-1:0] wrap_inc(input logic [ADDR_W-1:0] addr);
        return (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
    endfunction
endpackage

// File: rtl/hif_ptr_wrap.sv
// hif_ptr_wrap: loadable address counter wrapping DEPTH-1 -> 0; load wins over inc
module hif_ptr_wrap
    import hif_q_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] ld_val,
    input  logic              inc,
    output logic [ADDR_W-1:0] value
);
    always_ff @(posedge clk) begin
        if (rst)
            value <= '0;
        else
            value <= load ? ld_val : inc ? wrap_inc(value) : value;
    end
endmodule

// File: rtl/hif_queue_reader.sv
// hif_queue_reader: sweeps TAPS queue addresses from the oldest sample and streams them to the FIR.
// Optional OVERRUN_FLAG_EN adds sticky seq_overrun for sample pulses arriving mid-sequence.
module hif_queue_reader
    import hif_q_pkg::*;
#(
    parameter int TAPS = 1021
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrt_smpl,
    input  logic              q_full,
    input  logic [ADDR_W-1:0] old_ptr,
    output logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] smpl_out,
    output logic              smpl_vld,
    output logic [ADDR_W-1:0] coeff_addr,
    output logic              sequencing,
    output logic              seq_done
`ifdef OVERRUN_FLAG_EN
    ,
    output logic              seq_overrun
`endif
);
    rd_state_t         state, state_nxt;
    logic [ADDR_W-1:0] tap_cnt;
    logic              start, issue, last;

    assign start = (state == IDLE) && wrt_smpl && q_full;
    assign issue = (state == SEQ);
    assign last  = issue && (tap_cnt == ADDR_W'(TAPS - 1));

    hif_ptr_wrap u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .ld_val (old_ptr),
        .inc    (issue),
        .value  (raddr)
    );

    always_comb begin
        state_nxt  = state;
        sequencing = (state != IDLE);
        case (state)
            IDLE:    state_nxt = start ? SEQ : IDLE;
            SEQ:     state_nxt = last ? DRAIN : SEQ;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            tap_cnt    <= '0;
            smpl_vld   <= 1'b0;
            coeff_addr <= '0;
            seq_done   <= 1'b0;
        end else begin
            state      <= state_nxt;
            tap_cnt    <= start ? '0 : (issue && !last) ? tap_cnt + 1'b1 : tap_cnt;
            smpl_vld   <= issue;
            coeff_addr <= issue ? tap_cnt : '0;
            seq_done   <= (state == DRAIN);
        end
    end

    // RAM data arrives one cycle after the address, already aligned with smpl_vld
    assign smpl_out = smpl_vld ? rdata : '0;

`ifdef OVERRUN_FLAG_EN
    always_ff @(posedge clk) begin
        if (rst)
            seq_overrun <= 1'b0;
        else if (wrt_smpl && state != IDLE)
            seq_overrun <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_hif_queue_reader.sv
// tb_hif_queue_reader: scoreboard bench with a behavioural queue RAM and cycle-stamped expectations
module tb_hif_queue_reader;
    localparam int DEPTH = 1536;
    localparam int TAPS  = 1021;
    localparam int BIG   = 32'h7fffffff;

    typedef struct { int cyc; logic [10:0] addr; } a_t;
    typedef struct { int cyc; logic [10:0] coeff; logic [15:0] data; } v_t;

    logic        clk = 1'b0, rst = 1'b1, wrt_smpl = 1'b0, q_full = 1'b0;
    logic [10:0] old_ptr = '0, raddr, coeff_addr;
    logic [15:0] rdata = '0, smpl_out;
    logic        smpl_vld, sequencing, seq_done;
`ifdef OVERRUN_FLAG_EN
    logic        seq_overrun;
`endif

    logic [15:0] mem [DEPTH];
    a_t aq[$];
    v_t vq[$];
    int done_q[$];
    int cyc = 0, n_cmp = 0, n_err = 0;
    int seq_lo = 1, seq_hi = 0, ov_lo = BIG, ov_hi = BIG, zero_cyc = -1;
    bit armed = 0;

    hif_queue_reader #(.TAPS(TAPS)) dut (
        .clk        (clk),
        .rst        (rst),
        .wrt_smpl   (wrt_smpl),
        .q_full     (q_full),
        .old_ptr    (old_ptr),
        .raddr      (raddr),
        .rdata      (rdata),
        .smpl_out   (smpl_out),
        .smpl_vld   (smpl_vld),
        .coeff_addr (coeff_addr),
        .sequencing (sequencing),
        .seq_done   (seq_done)
`ifdef OVERRUN_FLAG_EN
        ,
        .seq_overrun(seq_overrun)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rdata <= mem[raddr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic qf, input logic [10:0] op);
        int t;
        t = cyc;
        wrt_smpl = 1'b1;
        q_full   = qf;
        old_ptr  = op;
        if (t >= seq_lo && t <= seq_hi) begin
            if (!(t >= ov_lo && t <= ov_hi)) begin
                ov_lo = t + 1;
                ov_hi = BIG;
            end
        end else if (qf) begin
            for (int i = 0; i < TAPS; i++) begin
                logic [10:0] a;
                a = 11'((int'(op) + i) % DEPTH);
                aq.push_back('{t + 1 + i, a});
                vq.push_back('{t + 2 + i, 11'(i), mem[a]});
            end
            done_q.push_back(t + TAPS + 2);
            seq_lo = t + 1;
            seq_hi = t + TAPS + 1;
        end
        tick();
        wrt_smpl = 1'b0;
    endtask

    task automatic do_reset();
        int c;
        c = cyc;
        rst = 1'b1;
        while (aq.size() && aq[$].cyc > c) void'(aq.pop_back());
        while (vq.size() && vq[$].cyc > c) void'(vq.pop_back());
        while (done_q.size() && done_q[$] > c) void'(done_q.pop_back());
        if (seq_hi > c) seq_hi = c;
        if (ov_lo <= c && ov_hi > c) ov_hi = c;
        zero_cyc = c + 1;
        armed = 1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(cyc >= seq_hi + 2 && aq.size() == 0 && vq.size() == 0 && done_q.size() == 0) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) check("idle_timeout", 1, 0);
    endtask

    always @(negedge clk) begin
        if (armed) begin
            if (cyc == zero_cyc) begin
                check("rst_raddr", raddr, 0);
                check("rst_vld", smpl_vld, 0);
                check("rst_coeff", coeff_addr, 0);
                check("rst_smpl", smpl_out, 0);
                check("rst_done", seq_done, 0);
            end
            check("sequencing", sequencing, (cyc >= seq_lo && cyc <= seq_hi));
`ifdef OVERRUN_FLAG_EN
            check("overrun", seq_overrun, (cyc >= ov_lo && cyc <= ov_hi));
`endif
            if (aq.size() && aq[0].cyc == cyc) begin
                check("raddr", raddr, aq[0].addr);
                void'(aq.pop_front());
            end
            if (vq.size() && vq[0].cyc == cyc) begin
                check("smpl_vld", smpl_vld, 1);
                check("coeff_addr", coeff_addr, vq[0].coeff);
                check("smpl_out", smpl_out, vq[0].data);
                void'(vq.pop_front());
            end else if (smpl_vld) check("spurious_vld", smpl_vld, 0);
            if (done_q.size() && done_q[0] == cyc) begin
                check("seq_done", seq_done, 1);
                void'(done_q.pop_front());
            end else if (seq_done) check("spurious_done", seq_done, 0);
        end
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
        tick();
        tick();
        do_reset();
        tick();
        // queue not yet full: pulse must be ignored
        pulse(1'b0, 11'd5);
        repeat (3) tick();
        check("t1_raddr", raddr, 0);
        // full sweep from address 0
        pulse(1'b1, 11'd0);
        wait_idle();
        // wrap across DEPTH-1 -> 0
        pulse(1'b1, 11'd1530);
        wait_idle();
        // overlapping pulse ignored
        pulse(1'b1, 11'd100);
        repeat (499) tick();
        pulse(1'b1, 11'd7);
        wait_idle();
        // reset mid-sequence then fresh start
        pulse(1'b1, 11'd20);
        repeat (299) tick();
        do_reset();
        tick();
        pulse(1'b1, 11'd1535);
        wait_idle();
        // back-to-back: new pulse coincident with seq_done
        pulse(1'b1, 11'd500);
        begin
            int n = 0;
            while (cyc < seq_hi + 1 && n < 3000) begin
                tick();
                n++;
            end
            if (n >= 3000) check("done_timeout", 1, 0);
        end
        pulse(1'b1, 11'd1000);
        wait_idle();
        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
